// File: rtl/pwm_cfg.sv
// Shadow/active configuration registers for the two-channel I/Q PWM timebase.
// Optional build macro PWM_CFG_CLAMP_EN clamps committed compares to the shadow period.
module pwm_cfg #(
   parameter int unsigned      WIDTH   = 18,
   parameter logic [WIDTH-1:0] PRD_RST = 18'h00008
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wb_cyc_i,
   input  logic             wb_stb_i,
   input  logic             wb_we_i,
   input  logic [1:0]       wb_adr_i,
   input  logic [7:0]       wb_dat_i,
   output logic [7:0]       wb_dat_o,
   output logic             wb_ack_o,
   input  logic             tb_zero_i,
   output logic [WIDTH-1:0] prd_o,
   output logic [WIDTH-1:0] cmph0_o,
   output logic [WIDTH-1:0] cmpl0_o,
   output logic [WIDTH-1:0] cmph1_o,
   output logic [WIDTH-1:0] cmpl1_o,
   output logic             upd_o,
   output logic             pending_o
);

   localparam logic [1:0] AdrData   = 2'd0;
   localparam logic [1:0] AdrSel    = 2'd1;
   localparam logic [1:0] AdrCtrl   = 2'd2;
   localparam logic [1:0] AdrStatus = 2'd3;

   localparam int unsigned NumRegs = 5;

   typedef enum logic [1:0] {
      ByteB0 = 2'd0,
      ByteB1 = 2'd1,
      ByteB2 = 2'd2
   } bptr_e;

   logic             ack_q, ack_d;
   logic [7:0]       rdat_q, rdat_d;
   logic [2:0]       sel_q, sel_d;
   bptr_e            bptr_q, bptr_d;
   logic [15:0]      stg_q, stg_d;
   logic             pending_q, pending_d;
   logic             upd_q, upd_d;
   logic [WIDTH-1:0] shd_q [NumRegs];
   logic [WIDTH-1:0] shd_d [NumRegs];
   logic [WIDTH-1:0] act_q [NumRegs];
   logic [WIDTH-1:0] act_d [NumRegs];

   logic             req, acc;
   logic             wr_data, wr_sel, wr_ctrl;
   logic             shd_we;
   logic             arm, now, commit;
   logic [WIDTH-1:0] asm_val;

   // Accesses are decoded in the request cycle for read data, and in the ack
   // cycle for writes so that state changes land on the ack edge.
   assign req     = wb_cyc_i & wb_stb_i & ~ack_q;
   assign acc     = wb_cyc_i & wb_stb_i & ack_q;
   assign wr_data = acc & wb_we_i & (wb_adr_i == AdrData);
   assign wr_sel  = acc & wb_we_i & (wb_adr_i == AdrSel);
   assign wr_ctrl = acc & wb_we_i & (wb_adr_i == AdrCtrl);

   assign ack_d = req;

   always_comb begin
      rdat_d = '0;
      if (req && !wb_we_i) begin
         case (wb_adr_i)
            AdrSel:    rdat_d = {5'b0, sel_q};
            AdrCtrl:   rdat_d = {7'b0, pending_q};
            AdrStatus: rdat_d = {2'b0, sel_q, bptr_q, pending_q};
            default:   rdat_d = '0;
         endcase
      end
   end

   always_comb begin
      sel_d = sel_q;
      if (wr_sel) begin
         sel_d = wb_dat_i[2:0];
      end
   end

   // Byte assembly; a SEL write restarts the sequence and drops partial bytes.
   always_comb begin
      bptr_d = bptr_q;
      stg_d  = stg_q;
      shd_we = 1'b0;
      if (wr_sel) begin
         bptr_d = ByteB0;
         stg_d  = '0;
      end else if (wr_data) begin
         case (bptr_q)
            ByteB0: begin
               stg_d[7:0] = wb_dat_i;
               bptr_d     = ByteB1;
            end
            ByteB1: begin
               stg_d[15:8] = wb_dat_i;
               bptr_d      = ByteB2;
            end
            ByteB2: begin
               shd_we = 1'b1;
               bptr_d = ByteB0;
            end
            default: bptr_d = ByteB0;
         endcase
      end
   end

   assign asm_val = {wb_dat_i[WIDTH-17:0], stg_q};

   // Unused selector values 5-7 match no index, so the write is dropped.
   always_comb begin
      for (int i = 0; i < NumRegs; i++) begin
         shd_d[i] = shd_q[i];
         if (shd_we && (sel_q == 3'(i))) begin
            shd_d[i] = asm_val;
         end
      end
   end

   // Immediate commit overrides arm; an arm write restarts the wait, so a
   // reload in the same cycle as the arm write is not taken.
   assign now    = wr_ctrl & wb_dat_i[1];
   assign arm    = wr_ctrl & wb_dat_i[0] & ~wb_dat_i[1];
   assign commit = now | (pending_q & tb_zero_i & ~arm);

   always_comb begin
      pending_d = pending_q;
      if (now) begin
         pending_d = 1'b0;
      end else if (arm) begin
         pending_d = 1'b1;
      end else if (commit) begin
         pending_d = 1'b0;
      end
   end

   assign upd_d = commit;

   always_comb begin
      for (int i = 0; i < NumRegs; i++) begin
         act_d[i] = act_q[i];
      end
      if (commit) begin
         act_d[0] = shd_q[0];
         for (int i = 1; i < NumRegs; i++) begin
`ifdef PWM_CFG_CLAMP_EN
            act_d[i] = (shd_q[i] > shd_q[0]) ? shd_q[0] : shd_q[i];
`else
            act_d[i] = shd_q[i];
`endif
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ack_q     <= 1'b0;
         rdat_q    <= '0;
         sel_q     <= '0;
         bptr_q    <= ByteB0;
         stg_q     <= '0;
         pending_q <= 1'b0;
         upd_q     <= 1'b0;
         shd_q     <= '{PRD_RST, '0, '0, '0, '0};
         act_q     <= '{PRD_RST, '0, '0, '0, '0};
      end else begin
         ack_q     <= ack_d;
         rdat_q    <= rdat_d;
         sel_q     <= sel_d;
         bptr_q    <= bptr_d;
         stg_q     <= stg_d;
         pending_q <= pending_d;
         upd_q     <= upd_d;
         shd_q     <= shd_d;
         act_q     <= act_d;
      end
   end

   assign wb_ack_o  = ack_q;
   assign wb_dat_o  = rdat_q;
   assign upd_o     = upd_q;
   assign pending_o = pending_q;
   assign prd_o     = act_q[0];
   assign cmph0_o   = act_q[1];
   assign cmpl0_o   = act_q[2];
   assign cmph1_o   = act_q[3];
   assign cmpl1_o   = act_q[4];

endmodule

// File: tb/tb_pwm_cfg.sv
// Scoreboard bench for pwm_cfg: read data and commit snapshots are queued by
// the stimulus and checked by a monitor when wb_ack_o / upd_o appear.
module tb_pwm_cfg;

   localparam int unsigned W = 18;

   typedef struct packed {
      logic [W-1:0] prd;
      logic [W-1:0] h0;
      logic [W-1:0] l0;
      logic [W-1:0] h1;
      logic [W-1:0] l1;
   } cfg_t;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         wb_cyc = 1'b0, wb_stb = 1'b0, wb_we = 1'b0;
   logic [1:0]   wb_adr = '0;
   logic [7:0]   wb_dwr = '0;
   logic [7:0]   wb_drd;
   logic         wb_ack;
   logic         tb_zero = 1'b0;
   logic [W-1:0] prd, cmph0, cmpl0, cmph1, cmpl1;
   logic         upd, pending;

   int checks = 0;
   int errors = 0;

   logic [7:0] rd_q [$];
   cfg_t       cfg_q [$];

   pwm_cfg #(.WIDTH(18), .PRD_RST(18'h00008)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .wb_cyc_i  (wb_cyc),
      .wb_stb_i  (wb_stb),
      .wb_we_i   (wb_we),
      .wb_adr_i  (wb_adr),
      .wb_dat_i  (wb_dwr),
      .wb_dat_o  (wb_drd),
      .wb_ack_o  (wb_ack),
      .tb_zero_i (tb_zero),
      .prd_o     (prd),
      .cmph0_o   (cmph0),
      .cmpl0_o   (cmpl0),
      .cmph1_o   (cmph1),
      .cmpl1_o   (cmpl1),
      .upd_o     (upd),
      .pending_o (pending)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%05h expected 0x%05h", name, act, exp);
      end
   endtask

   task automatic push_cfg(input logic [W-1:0] p, input logic [W-1:0] h0, input logic [W-1:0] l0,
                           input logic [W-1:0] h1, input logic [W-1:0] l1);
      cfg_t c;
      c.prd = p; c.h0 = h0; c.l0 = l0; c.h1 = h1; c.l1 = l1;
      cfg_q.push_back(c);
   endtask

   // Returns #1 after the edge ending the ack cycle, i.e. when the access has taken effect.
   task automatic bus(input logic we, input logic [1:0] adr, input logic [7:0] dat,
                      input logic zero_on_ack);
      int n;
      @(posedge clk); #1;
      wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_adr = adr; wb_dwr = dat;
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!wb_ack && n < 20);
      if (!wb_ack) begin
         checks++;
         errors++;
         $display("FAIL ack_timeout: got no ack expected ack within 20 cycles");
      end
      if (zero_on_ack) tb_zero = 1'b1;
      @(posedge clk); #1;
      wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
      tb_zero = 1'b0;
   endtask

   task automatic wr(input logic [1:0] adr, input logic [7:0] dat);
      bus(1'b1, adr, dat, 1'b0);
   endtask

   task automatic rd(input logic [1:0] adr, input logic [7:0] exp);
      rd_q.push_back(exp);
      bus(1'b0, adr, 8'h00, 1'b0);
   endtask

   task automatic pulse_zero();
      @(posedge clk); #1 tb_zero = 1'b1;
      @(posedge clk); #1 tb_zero = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Monitor: compares read data on ack and the active configuration on upd_o.
   always @(negedge clk) begin
      if (rst_n) begin
         if (wb_ack && !wb_we) begin
            if (rd_q.size() == 0) begin
               chk("rd_unexpected", 32'(wb_drd), 32'hxx);
            end else begin
               chk("rd_data", 32'(wb_drd), 32'(rd_q.pop_front()));
            end
         end
         if (upd) begin
            if (cfg_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL upd_unexpected: got upd_o=1 expected no commit");
            end else begin
               cfg_t e;
               e = cfg_q.pop_front();
               chk("commit_prd", 32'(prd), 32'(e.prd));
               chk("commit_cmph0", 32'(cmph0), 32'(e.h0));
               chk("commit_cmpl0", 32'(cmpl0), 32'(e.l0));
               chk("commit_cmph1", 32'(cmph1), 32'(e.h1));
               chk("commit_cmpl1", 32'(cmpl1), 32'(e.l1));
            end
         end
      end
   end

   initial begin
      #12 rst_n = 1'b1;
      idle(2);

      // Reset state
      chk("rst_prd", 32'(prd), 32'h00008);
      chk("rst_cmph0", 32'(cmph0), 0);
      chk("rst_cmpl0", 32'(cmpl0), 0);
      chk("rst_cmph1", 32'(cmph1), 0);
      chk("rst_cmpl1", 32'(cmpl1), 0);
      chk("rst_pending", 32'(pending), 0);
      chk("rst_upd", 32'(upd), 0);
      rd(2'd3, 8'h00);
      rd(2'd0, 8'h00);

      // Immediate commit of PRD; 0xFF contributes only bits 17:16
      wr(2'd1, 8'h00);
      wr(2'd0, 8'h34);
      wr(2'd0, 8'h12);
      wr(2'd0, 8'hFF);
      rd(2'd3, 8'h00);
      push_cfg(18'h31234, 0, 0, 0, 0);
      wr(2'd2, 8'h02);
      chk("imm_prd", 32'(prd), 32'h31234);
      idle(3);
      pulse_zero();
      idle(2);

      // Armed commit of CMPH0
      wr(2'd1, 8'h01);
      rd(2'd1, 8'h01);
      wr(2'd0, 8'h00);
      wr(2'd0, 8'h01);
      wr(2'd0, 8'h00);
      wr(2'd2, 8'h01);
      chk("arm_pending", 32'(pending), 1);
      rd(2'd2, 8'h01);
      rd(2'd3, 8'h09);
      idle(3);
      chk("arm_hold_cmph0", 32'(cmph0), 0);
      push_cfg(18'h31234, 18'h00100, 0, 0, 0);
      pulse_zero();
      chk("arm_cmph0", 32'(cmph0), 32'h00100);
      chk("arm_cleared", 32'(pending), 0);
      idle(2);

      // Arm acked together with tb_zero: commit waits for the next reload
      wr(2'd1, 8'h03);
      wr(2'd0, 8'h07);
      wr(2'd0, 8'h00);
      wr(2'd0, 8'h00);
      bus(1'b1, 2'd2, 8'h01, 1'b1);
      chk("same_cyc_pending", 32'(pending), 1);
      chk("same_cyc_cmph1", 32'(cmph1), 0);
      idle(10);
      chk("same_cyc_still_pending", 32'(pending), 1);
      push_cfg(18'h31234, 18'h00100, 0, 18'h00007, 0);
      pulse_zero();
      chk("late_cmph1", 32'(cmph1), 32'h00007);
      chk("late_cleared", 32'(pending), 0);
      idle(2);

      // SEL write discards partial assembly
      wr(2'd1, 8'h02);
      wr(2'd0, 8'hAA);
      wr(2'd0, 8'hBB);
      rd(2'd3, 8'h14);
      wr(2'd1, 8'h02);
      rd(2'd3, 8'h10);
      wr(2'd0, 8'h05);
      wr(2'd0, 8'h00);
      wr(2'd0, 8'h00);
      push_cfg(18'h31234, 18'h00100, 18'h00005, 18'h00007, 0);
      wr(2'd2, 8'h02);
      idle(2);

      // Selector 5 writes nothing; both CTRL bits behave as immediate
      wr(2'd1, 8'h05);
      wr(2'd0, 8'h11);
      wr(2'd0, 8'h22);
      wr(2'd0, 8'h03);
      rd(2'd3, 8'h28);
      push_cfg(18'h31234, 18'h00100, 18'h00005, 18'h00007, 0);
      wr(2'd2, 8'h03);
      chk("both_bits_pending", 32'(pending), 0);
      idle(2);

      // Compare above period
      wr(2'd1, 8'h00);
      wr(2'd0, 8'h10);
      wr(2'd0, 8'h00);
      wr(2'd0, 8'h00);
      wr(2'd1, 8'h03);
      wr(2'd0, 8'h20);
      wr(2'd0, 8'h00);
      wr(2'd0, 8'h00);
`ifdef PWM_CFG_CLAMP_EN
      push_cfg(18'h00010, 18'h00010, 18'h00005, 18'h00010, 0);
`else
      push_cfg(18'h00010, 18'h00100, 18'h00005, 18'h00020, 0);
`endif
      wr(2'd2, 8'h02);
      idle(2);
      // Shadows must keep their unclamped contents
      wr(2'd1, 8'h00);
      wr(2'd0, 8'h40);
      wr(2'd0, 8'h00);
      wr(2'd0, 8'h00);
`ifdef PWM_CFG_CLAMP_EN
      push_cfg(18'h00040, 18'h00040, 18'h00005, 18'h00020, 0);
`else
      push_cfg(18'h00040, 18'h00100, 18'h00005, 18'h00020, 0);
`endif
      wr(2'd2, 8'h02);
      idle(2);

      // Asynchronous reset mid-assembly with a commit armed
      wr(2'd2, 8'h01);
      wr(2'd1, 8'h04);
      wr(2'd0, 8'h11);
      wr(2'd0, 8'h22);
      @(posedge clk); #3 rst_n = 1'b0;
      #1;
      chk("arst_prd", 32'(prd), 32'h00008);
      chk("arst_cmph0", 32'(cmph0), 0);
      chk("arst_cmpl0", 32'(cmpl0), 0);
      chk("arst_cmph1", 32'(cmph1), 0);
      chk("arst_pending", 32'(pending), 0);
      chk("arst_ack", 32'(wb_ack), 0);
      idle(2);
      rst_n = 1'b1;
      idle(1);
      rd(2'd3, 8'h00);
      push_cfg(18'h00008, 0, 0, 0, 0);
      wr(2'd2, 8'h02);
      idle(4);

      chk("rd_queue_empty", 32'(rd_q.size()), 0);
      chk("cfg_queue_empty", 32'(cfg_q.size()), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule
